// File: rtl/gpio_pkg.sv
// Shared definitions for the switch/LED peripheral: word offsets of the
// register map, edge-capture mode encoding and the identification word.
package gpio_pkg;

    localparam logic [2:0] OFF_SW_STATE = 3'd0;
    localparam logic [2:0] OFF_LED_OUT  = 3'd1;
    localparam logic [2:0] OFF_LED_SET  = 3'd2;
    localparam logic [2:0] OFF_LED_CLR  = 3'd3;
    localparam logic [2:0] OFF_LED_TGL  = 3'd4;
    localparam logic [2:0] OFF_EDGE     = 3'd5;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd6;
    localparam logic [2:0] OFF_ID       = 3'd7;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    localparam logic [7:0] ID_MAGIC = 8'hA1;

    function automatic logic [31:0] id_word(input int n_sw, input int n_led, input int mode);
        return {ID_MAGIC, 8'(n_sw), 8'(n_led), 8'(mode)};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: multi-flop synchroniser followed by a stability counter.
// The edge pulses are asserted in the cycle before stable flips, so a
// register sampling them updates on the same clock edge as stable.
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   sync_s;
    logic                   differ_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic                   accept_s;

    assign sync_s    = sync_r[SYNC_STAGES-1];
    assign differ_s  = (sync_s != stable_r);
    assign cnt_inc_s = cnt_r + CNT_W'(1);
    assign accept_s  = differ_s && (cnt_inc_s == CNT_DONE);

    // Synchroniser chain for the asynchronous switch input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sw};
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle drops the glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (!differ_s) begin
            cnt_r    <= '0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            stable_r <= sync_s;
        end else begin
            cnt_r    <= cnt_inc_s;
        end
    end

    assign stable     = stable_r;
    assign rise_pulse = accept_s & sync_s;
    assign fall_pulse = accept_s & ~sync_s;

endmodule

// File: rtl/gpio_periph.sv
// Memory-mapped switch/LED peripheral: debounced switch state, sticky edge
// capture with W1C, maskable interrupt and LED set/clear/toggle operations.
module gpio_periph
    import gpio_pkg::*;
#(
    parameter int          N_SW            = 10,
    parameter int          N_LED           = 10,
    parameter logic [31:0] BASE_ADDR       = 32'hC000_0000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          EDGE_MODE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_addr,
    input  logic             mem_we,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             hit,
    input  logic [N_SW-1:0]  switches,
    output logic [N_LED-1:0] leds,
    output logic             irq
);

    localparam edge_mode_t MODE = edge_mode_t'(2'(EDGE_MODE));

    logic [N_SW-1:0]  stable_s;
    logic [N_SW-1:0]  rise_s;
    logic [N_SW-1:0]  fall_s;
    logic [N_SW-1:0]  edge_set_s;
    logic [N_SW-1:0]  edge_clr_s;
    logic [N_SW-1:0]  edge_next_s;
    logic [N_SW-1:0]  irq_en_next_s;
    logic [N_LED-1:0] led_next_s;
    logic [N_SW-1:0]  edge_r;
    logic [N_SW-1:0]  irq_en_r;
    logic [N_LED-1:0] led_r;
    logic             irq_r;
    logic             hit_s;
    logic             wr_s;
    logic [2:0]       off_s;
    logic [7:0]       wr_sel_s;
    logic [N_LED-1:0] wd_led_s;
    logic [N_SW-1:0]  wd_sw_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sw_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst_n      (reset),
            .sw         (switches[i]),
            .stable     (stable_s[i]),
            .rise_pulse (rise_s[i]),
            .fall_pulse (fall_s[i])
        );
    end

    assign hit_s    = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign off_s    = mem_addr[4:2];
    assign wr_s     = hit_s & mem_we;
    assign wr_sel_s = wr_s ? (8'b0000_0001 << off_s) : 8'b0000_0000;
    assign wd_led_s = mem_wdata[N_LED-1:0];
    assign wd_sw_s  = mem_wdata[N_SW-1:0];
    assign unused_s = ^{mem_addr[1:0], mem_wdata};

    // Select which debounced transitions count as an edge.
    always_comb begin
        case (MODE)
            EDGE_RISE: edge_set_s = rise_s;
            EDGE_FALL: edge_set_s = fall_s;
            EDGE_BOTH: edge_set_s = rise_s | fall_s;
            default:   edge_set_s = rise_s | fall_s;
        endcase
    end

    // Next-state for LED, EDGE and IRQ_EN; a fresh edge beats a same-cycle W1C.
    always_comb begin
        led_next_s    = led_r;
        irq_en_next_s = irq_en_r;
        edge_clr_s    = wr_sel_s[OFF_EDGE] ? wd_sw_s : '0;
        edge_next_s   = (edge_r & ~edge_clr_s) | edge_set_s;
        if (wr_sel_s[OFF_LED_OUT]) begin
            led_next_s = wd_led_s;
        end else if (wr_sel_s[OFF_LED_SET]) begin
            led_next_s = led_r | wd_led_s;
        end else if (wr_sel_s[OFF_LED_CLR]) begin
            led_next_s = led_r & ~wd_led_s;
        end else if (wr_sel_s[OFF_LED_TGL]) begin
            led_next_s = led_r ^ wd_led_s;
        end else begin
            led_next_s = led_r;
        end
        if (wr_sel_s[OFF_IRQ_EN]) begin
            irq_en_next_s = wd_sw_s;
        end else begin
            irq_en_next_s = irq_en_r;
        end
    end

    // Register file state and the registered interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r    <= '0;
            edge_r   <= '0;
            irq_en_r <= '0;
            irq_r    <= 1'b0;
        end else begin
            led_r    <= led_next_s;
            edge_r   <= edge_next_s;
            irq_en_r <= irq_en_next_s;
            irq_r    <= |(edge_r & irq_en_r);
        end
    end

    // Side-effect-free read mux; write-only offsets and misses read zero.
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            case (off_s)
                OFF_SW_STATE: rdata_s[N_SW-1:0]  = stable_s;
                OFF_LED_OUT:  rdata_s[N_LED-1:0] = led_r;
                OFF_EDGE:     rdata_s[N_SW-1:0]  = edge_r;
                OFF_IRQ_EN:   rdata_s[N_SW-1:0]  = irq_en_r;
                OFF_ID:       rdata_s = id_word(N_SW, N_LED, EDGE_MODE);
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign mem_rdata = rdata_s;
    assign hit       = hit_s;
    assign leds      = led_r;
    assign irq       = irq_r;

endmodule

// File: tb/tb_gpio_periph.sv
// Bench for gpio_periph: directed vector table, hand-timed corner sequences
// and a randomized phase checked against a window-based reference model.
`timescale 1ns/1ps
module tb_gpio_periph;

    localparam int          NSW  = 10;
    localparam int          NLED = 10;
    localparam int          SYNC = 2;
    localparam int          DEB  = 4;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     mem_addr = 32'd0;
    logic            mem_we = 1'b0;
    logic [31:0]     mem_wdata = 32'd0;
    logic [31:0]     mem_rdata;
    logic            hit;
    logic [NSW-1:0]  switches = '0;
    logic [NLED-1:0] leds;
    logic            irq;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    gpio_periph dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .hit       (hit),
        .switches  (switches),
        .leds      (leds),
        .irq       (irq)
    );

    // Reference model: a switch value is accepted once the last DEB synchronised
    // samples all disagree with the accepted state.
    logic [NSW-1:0]  m_pipe [SYNC];
    logic [NSW-1:0]  m_seen [DEB];
    logic [NSW-1:0]  m_stable, m_edge, m_en;
    logic [NLED-1:0] m_leds;
    logic            m_irq;

    task automatic model_reset();
        for (int s = 0; s < SYNC; s++) m_pipe[s] = '0;
        for (int s = 0; s < DEB; s++) m_seen[s] = '0;
        m_stable = '0; m_edge = '0; m_en = '0; m_leds = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [NSW-1:0]  cur, flip, clr, wsw;
        logic [NLED-1:0] wl;
        logic            irq_n, wr;
        logic [2:0]      off;
        irq_n = |(m_edge & m_en);
        cur = m_pipe[SYNC-1];
        for (int s = SYNC-1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = switches;
        for (int s = DEB-1; s > 0; s--) m_seen[s] = m_seen[s-1];
        m_seen[0] = cur;
        flip = '1;
        for (int s = 0; s < DEB; s++) flip = flip & (m_seen[s] ^ m_stable);
        wr  = mem_we && (mem_addr[31:5] == BASE[31:5]);
        off = mem_addr[4:2];
        wsw = mem_wdata[NSW-1:0];
        wl  = mem_wdata[NLED-1:0];
        clr = (wr && off == 3'd5) ? wsw : '0;
        m_edge = (m_edge & ~clr) | flip;
        if (wr) begin
            case (off)
                3'd1: m_leds = wl;
                3'd2: m_leds = m_leds | wl;
                3'd3: m_leds = m_leds & ~wl;
                3'd4: m_leds = m_leds ^ wl;
                3'd6: m_en = wsw;
                default: ;
            endcase
        end
        m_stable = m_stable ^ flip;
        m_irq = irq_n;
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] d;
        d = 32'd0;
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0: d = 32'(m_stable);
                3'd1: d = 32'(m_leds);
                3'd5: d = 32'(m_edge);
                3'd6: d = 32'(m_en);
                3'd7: d = 32'hA10A_0A02;
                default: d = 32'd0;
            endcase
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #2;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
        mem_we = 1'b0;
        mem_addr = BASE + {27'd0, off, 2'b00};
        #1;
        chk(name, mem_rdata, exp);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        mem_addr = BASE + {27'd0, off, 2'b00};
        mem_we = 1'b1;
        mem_wdata = d;
        tick();
        mem_we = 1'b0;
    endtask

    typedef struct {
        logic [31:0]     addr;
        logic            we;
        logic [31:0]     wdata;
        logic [31:0]     rd_addr;
        logic [31:0]     exp_rd;
        logic            exp_hit;
        logic [NLED-1:0] exp_leds;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{BASE + 32'h04, 1'b1, 32'h0000_03FF, BASE + 32'h04, 32'h0000_03FF, 1'b1, 10'h3FF};
        vecs[1] = '{BASE + 32'h0C, 1'b1, 32'h0000_000F, BASE + 32'h04, 32'h0000_03F0, 1'b1, 10'h3F0};
        vecs[2] = '{BASE + 32'h10, 1'b1, 32'h0000_0201, BASE + 32'h04, 32'h0000_01F1, 1'b1, 10'h1F1};
        vecs[3] = '{BASE + 32'h08, 1'b1, 32'h0000_0001, BASE + 32'h04, 32'h0000_01F1, 1'b1, 10'h1F1};
        vecs[4] = '{BASE + 32'h1C, 1'b0, 32'h0000_0000, BASE + 32'h1C, 32'hA10A_0A02, 1'b1, 10'h1F1};
        vecs[5] = '{BASE + 32'h24, 1'b1, 32'h0000_0000, BASE + 32'h20, 32'h0000_0000, 1'b0, 10'h1F1};
        vecs[6] = '{BASE + 32'h00, 1'b1, 32'h0000_03FF, BASE + 32'h00, 32'h0000_0004, 1'b1, 10'h1F1};
        vecs[7] = '{BASE + 32'h06, 1'b1, 32'h0000_0055, BASE + 32'h07, 32'h0000_0055, 1'b1, 10'h055};
        vecs[8] = '{BASE + 32'h08, 1'b1, 32'h0000_0300, BASE + 32'h08, 32'h0000_0000, 1'b1, 10'h355};
        vecs[9] = '{BASE + 32'h04, 1'b1, 32'hFFFF_FC00, BASE + 32'h04, 32'h0000_0000, 1'b1, 10'h000};

        // Reset with switch 2 held high: power-up snapshot.
        switches = 10'd4;
        model_reset();
        #15;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_sw_state", 3'd0, 32'd0);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd_chk("pwrup_sw_state", 3'd0, (k == 6) ? 32'd4 : 32'd0);
        end
        rd_chk("pwrup_edge", 3'd5, 32'd4);
        tick();
        chk("pwrup_irq", 32'(irq), 32'd0);

        // 3-cycle glitch on switch 0 is rejected.
        switches[0] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        switches[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            rd_chk("glitch_sw_state", 3'd0, 32'd4);
        end
        rd_chk("glitch_edge", 3'd5, 32'd4);

        // 4-cycle pulse is accepted on rise and again on fall.
        switches[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        switches[0] = 1'b0;
        tick();
        rd_chk("pulse_pre_sw_state", 3'd0, 32'd4);
        tick();
        rd_chk("pulse_sw_state", 3'd0, 32'd5);
        rd_chk("pulse_edge", 3'd5, 32'd5);
        for (int k = 0; k < 4; k++) tick();
        rd_chk("pulse_fall_sw_state", 3'd0, 32'd4);
        wr(3'd5, 32'd1);
        rd_chk("w1c_edge0", 3'd5, 32'd4);

        // Register map vector table.
        for (int i = 0; i < 10; i++) begin
            mem_addr = vecs[i].addr;
            mem_we = vecs[i].we;
            mem_wdata = vecs[i].wdata;
            tick();
            mem_we = 1'b0;
            mem_addr = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rd);
        end

        // Interrupt enable, then W1C drop.
        wr(3'd6, 32'd4);
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        wr(3'd5, 32'd4);
        rd_chk("irq_edge_cleared", 3'd5, 32'd0);
        tick();
        chk("irq_clear", 32'(irq), 32'd0);

        // W1C on the same edge as a new falling edge on bit 2: set wins.
        switches[2] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rd_chk("coll_pre_sw", 3'd0, 32'd4);
        rd_chk("coll_pre_edge", 3'd5, 32'd0);
        wr(3'd5, 32'd4);
        rd_chk("coll_sw", 3'd0, 32'd0);
        rd_chk("coll_edge", 3'd5, 32'd4);
        wr(3'd5, 32'h3FF);

        // Reset mid-debounce on switch 5.
        wr(3'd1, 32'h2AA);
        switches[2] = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        tick();
        chk("pre_rst_irq", 32'(irq), 32'd1);
        switches[5] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_leds", 32'(leds), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        rd_chk("mid_rst_sw", 3'd0, 32'd0);
        rd_chk("mid_rst_edge", 3'd5, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd_chk("rerun_sw_state", 3'd0, (k == 6) ? 32'h24 : 32'd0);
        end
        rd_chk("rerun_edge", 3'd5, 32'h24);
        wr(3'd5, 32'h24);
        for (int k = 0; k < 10; k++) tick();
        rd_chk("rerun_edge_once", 3'd5, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            logic [2:0]  off;
            logic [31:0] a;
            off = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? (BASE + 32'h20 + {27'd0, off, 2'b00})
                                            : (BASE + {27'd0, off, 2'b00} + 32'($urandom_range(0, 3)));
            mem_addr = a;
            mem_we = ($urandom_range(0, 1) == 1);
            mem_wdata = $urandom;
            if ($urandom_range(0, 2) == 0)
                switches[$urandom_range(0, NSW-1)] ^= 1'b1;
            tick();
            chk("rnd_leds", 32'(leds), 32'(m_leds));
            chk("rnd_irq", 32'(irq), 32'(m_irq));
            mem_we = 1'b0;
            a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
            mem_addr = a;
            #1;
            chk("rnd_hit", 32'(hit), 32'(a[31:5] == BASE[31:5]));
            chk("rnd_rdata", mem_rdata, mread(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_periph.md
Name: gpio_periph

Overview:
- Memory-mapped switch/LED peripheral for the single-cycle ARM core's data bus; generalises the fixed 10-switch/10-LED I/O into parametrised widths.
- Adds input synchronisation, per-bit debounce, edge capture with W1C status, and a maskable interrupt.
- LED control supports direct write plus atomic set, clear and toggle.
- Sits beside data memory in top; the core reaches it via address decode on BASE_ADDR.

Parameters:
- N_SW, 10, number of switch inputs (1..32).
- N_LED, 10, number of LED outputs (1..32).
- BASE_ADDR, 32'hC000_0000, peripheral base; 32-byte aligned.
- SYNC_STAGES, 2, synchroniser flops per switch (>=2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a change (>=1); counter width is $clog2(DEBOUNCE_CYCLES+1).
- EDGE_MODE, 2, edge capture mode: 0 rising, 1 falling, 2 both.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  in  32  byte address from the core.
- mem_we  in  1  write enable, qualified by address hit.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data, combinational.
- hit  out  1  mem_addr lies in [BASE_ADDR, BASE_ADDR+0x1F]; top muxes mem_rdata on it.
- switches  in  N_SW  raw asynchronous switch inputs.
- leds  out  N_LED  registered LED drive.
- irq  out  1  |(EDGE & IRQ_EN), registered.

Behaviour:
- Register map (offsets): 0x00 SW_STATE (RO, debounced); 0x04 LED_OUT (RW); 0x08 LED_SET (WO, W1S); 0x0C LED_CLR (WO, W1C); 0x10 LED_TGL (WO, W1T); 0x14 EDGE (RW1C); 0x18 IRQ_EN (RW); 0x1C ID (RO, {8'hA1, 8'(N_SW), 8'(N_LED), 8'(EDGE_MODE)}).
- Decode: hit = (mem_addr[31:5] == BASE_ADDR[31:5]); offset = mem_addr[4:2]; mem_addr[1:0] ignored.
- Reads are combinational, zero-latency and side-effect-free. Narrow fields are zero-extended. WO offsets read 0. mem_rdata = 0 when !hit.
- Writes commit on the rising clk edge when hit & mem_we. Only wdata[N-1:0] is used. Writes to RO offsets are ignored.
- Reset (async assert, sync release via the reset net): leds=0, EDGE=0, IRQ_EN=0, irq=0, synchroniser flops=0, debounced state=0, counters=0, mem_rdata follows the reset state.
- Per-switch pipeline:
  - Synchroniser: SYNC_STAGES flops.
  - Debounce: cnt increments while sync != stable. When cnt reaches DEBOUNCE_CYCLES, stable <= sync and cnt <= 0. cnt <= 0 on any cycle where sync == stable, so a glitch shorter than DEBOUNCE_CYCLES is dropped.
  - Latency from a clean switch transition to SW_STATE change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge capture: stable transition matching EDGE_MODE sets EDGE[i] in the cycle stable updates. Sticky until cleared by writing 1 to EDGE[i]. If a W1C and a new edge hit the same bit in the same cycle, set wins.
- irq: registered, one cycle after EDGE or IRQ_EN changes.
- Switches held high through reset: after release, stable rises after the latency above and logs a rising edge. This is intended and is the power-up snapshot.
- LED ops act on the full vector in one cycle. Only one offset is addressed per cycle, so SET/CLR/TGL never collide.
- Reset asserted mid-debounce: counters and state clear immediately; no edge is logged for the aborted change.

Decomposition:
- Package gpio_pkg:
  - Offset localparams: OFF_SW_STATE … OFF_ID.
  - typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_t.
  - ID_MAGIC = 8'hA1.
- Sub-module sw_debounce: one bit; synchroniser, counter and stable flop; outputs stable, rise_pulse and fall_pulse. Instantiate N_SW times with generate.
- The register file and decode stay in gpio_periph.

Test Plan:
- Reset release with switches=10'd4 (defaults) -> SW_STATE reads 0x004 exactly 6 cycles after the first sampling edge; EDGE=0x004; irq stays 0 because IRQ_EN=0.
- Switch 0 pulsed high for 3 cycles, then low -> SW_STATE[0] never set, EDGE[0]=0; a 4-cycle-stable pulse sets both.
- Write LED_OUT=0x3FF, then LED_CLR=0x00F, then LED_TGL=0x201, then LED_SET=0x001 -> leds = 0x3FF, 0x3F0, 0x1F1, 0x1F1; LED_OUT readback matches after each.
- IRQ_EN=0x004 with EDGE[2]=1 -> irq=1 next cycle. Write EDGE=0x004 -> irq=0 the cycle after. Same-cycle W1C plus new falling edge on bit 2 -> EDGE[2] stays 1.
- Read at BASE+0x1C -> 0xA10A0A02; read at BASE+0x20 -> hit=0, mem_rdata=0; write to SW_STATE leaves it unchanged.
- Assert reset while switch 5 is mid-debounce (cnt=2) -> all outputs 0 asynchronously; after release, the change is re-debounced from cnt=0 and the edge is logged once.
